// File: rtl/seg_scan_if.sv
// seg_scan_if: bundles the score/life digits feeding the display scanner and the
// digit-enable / segment outputs it drives.
//   fenshu2/1/0 : score BCD digits (hundreds, tens, units)
//   shengming   : life count, binary 0..15
//   an          : active-low digit enables, an[3] is the leftmost digit
//   seg         : active-low segments, seg[7]=dp, seg[6:0]=gfedcba
// master drives the digits and observes the display; slave is the scanner.
interface seg_scan_if;
  logic [3:0] fenshu2;
  logic [3:0] fenshu1;
  logic [3:0] fenshu0;
  logic [3:0] shengming;
  logic [3:0] an;
  logic [7:0] seg;

  modport master (
    output fenshu2, fenshu1, fenshu0, shengming,
    input  an, seg
  );

  modport slave (
    input  fenshu2, fenshu1, fenshu0, shengming,
    output an, seg
  );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: four-digit time-multiplexed seven-segment driver.
// Slots idx0..idx2 show the score hundreds/tens/units, idx3 shows the life count.
// All four inputs are snapshotted once per frame (on the tick entering idx0) so a
// frame never mixes old and new values. Leading zeros of the score are blanked and
// the whole display blinks while the snapshotted life is 0.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : seg_scan_if slave (digit inputs, an/seg outputs)
module seg_scan #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PreMax = PW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FrmMax = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    s2_q, s2_d, s1_q, s1_d, s0_q, s0_d, sl_q, sl_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  logic          dark_q, dark_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick, wrap;
  logic [3:0]    digit, en;
  logic          blank, is_life;
  logic [7:0]    seg_n;

  // Active-low gfedcba pattern; score slots show a dash for non-BCD values.
  function automatic logic [6:0] seg7(input logic [3:0] v, input logic life);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h40;
      4'h1:    p = 7'h79;
      4'h2:    p = 7'h24;
      4'h3:    p = 7'h30;
      4'h4:    p = 7'h19;
      4'h5:    p = 7'h12;
      4'h6:    p = 7'h02;
      4'h7:    p = 7'h78;
      4'h8:    p = 7'h00;
      4'h9:    p = 7'h10;
      4'hA:    p = 7'h08;
      4'hB:    p = 7'h03;
      4'hC:    p = 7'h46;
      4'hD:    p = 7'h21;
      4'hE:    p = 7'h06;
      default: p = 7'h0E;
    endcase
    if (!life && (v > 4'd9)) p = 7'h3F;
    return p;
  endfunction

  always_comb begin
    tick  = (pre_q == PreMax);
    wrap  = tick && (idx_q == 2'd3);
    pre_d = tick ? '0 : pre_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    s2_d = s2_q;
    s1_d = s1_q;
    s0_d = s0_q;
    sl_d = sl_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    dark_d  = dark_q;
    if (wrap) begin
      s2_d = bus.fenshu2;
      s1_d = bus.fenshu1;
      s0_d = bus.fenshu0;
      sl_d = bus.shengming;
      // The blink decision is latched per frame from the phase in force before
      // this wrap, so a whole frame is either lit or dark.
      dark_d = (bus.shengming == 4'd0) && !phase_q;
      if (frm_q == FrmMax) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // Output for the slot being entered, built from next-state snapshot so the
    // idx0 slot already shows the values captured on this same edge.
    digit   = 4'h0;
    en      = 4'b1111;
    blank   = 1'b0;
    is_life = 1'b0;
    unique case (idx_d)
      2'd0: begin
        digit = s2_d;
        en    = 4'b0111;
        blank = (s2_d == 4'd0);
      end
      2'd1: begin
        digit = s1_d;
        en    = 4'b1011;
        blank = (s2_d == 4'd0) && (s1_d == 4'd0);
      end
      2'd2: begin
        digit = s0_d;
        en    = 4'b1101;
      end
      2'd3: begin
        digit   = sl_d;
        en      = 4'b1110;
        is_life = 1'b1;
      end
    endcase
    seg_n = blank ? 8'hFF : {(idx_d != 2'd2), seg7(digit, is_life)};

    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      an_d  = dark_d ? 4'b1111 : en;
      seg_d = seg_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      idx_q   <= 2'd3;
      s2_q    <= 4'd0;
      s1_q    <= 4'd0;
      s0_q    <= 4'd0;
      sl_q    <= 4'd0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      dark_q  <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 8'hFF;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      s2_q    <= s2_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      sl_q    <= sl_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      dark_q  <= dark_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed + randomized bench for seg_scan. A cycle-count based model
// derives the expected slot, frame, snapshot and blink state from elapsed time
// since reset and is compared against an/seg every cycle.
module tb_seg_scan;
  localparam int unsigned CD = 4;
  localparam int unsigned BF = 2;

  logic clk;
  logic rst_n;
  seg_scan_if bus ();

  seg_scan #(
    .CLK_DIV      (CD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: edges since the last reset edge and the current frame snapshot.
  int         c = 0;
  logic [3:0] m2 = 4'd0, m1 = 4'd0, m0 = 4'd0, ml = 4'd0;
  logic [6:0] hexpat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_slot();
    if (c < int'(CD)) return -1;
    return ((c / CD) - 1) % 4;
  endfunction

  function automatic void model_out(output logic [3:0] ea, output logic [7:0] es);
    int s, f;
    logic [3:0] v;
    logic [6:0] p;
    logic dark;
    ea = 4'b1111;
    es = 8'hFF;
    if (c >= int'(CD)) begin
      s = model_slot();
      f = ((c / CD) - 1) / 4;
      v = (s == 0) ? m2 : (s == 1) ? m1 : (s == 2) ? m0 : ml;
      p = ((s < 3) && (v > 4'd9)) ? 7'h3F : hexpat[v];
      es = {(s != 2), p};
      if ((s == 0 && m2 == 4'd0) || (s == 1 && m2 == 4'd0 && m1 == 4'd0)) es = 8'hFF;
      dark = (ml == 4'd0) && (((f / BF) % 2) == 0);
      ea = dark ? 4'b1111 : ~(4'b1000 >> s);
    end
  endfunction

  // One clock: inputs as present at the edge feed the model, outputs checked at +1.
  task automatic step();
    logic r;
    logic [3:0] p2, p1, p0, pl, ea;
    logic [7:0] es;
    r  = rst_n;
    p2 = bus.fenshu2;
    p1 = bus.fenshu1;
    p0 = bus.fenshu0;
    pl = bus.shengming;
    @(posedge clk);
    if (!r) begin
      c = 0;
    end else begin
      c++;
      if ((c >= int'(CD)) && (((c - CD) % (4 * CD)) == 0)) begin
        m2 = p2;
        m1 = p1;
        m0 = p0;
        ml = pl;
      end
    end
    #1;
    model_out(ea, es);
    chk("an_model", {4'h0, bus.an}, {4'h0, ea});
    chk("seg_model", bus.seg, es);
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic [3:0] l);
    bus.fenshu2   = a;
    bus.fenshu1   = b;
    bus.fenshu0   = d;
    bus.shengming = l;
  endtask

  // Step until the model enters slot s (first cycle of it), bounded.
  task automatic wait_slot(input int s, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(model_slot() == s && (c % CD) == 0) && n < 64);
    chk(tag, {7'h0, (model_slot() == s)}, 8'h01);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(4'd1, 4'd2, 4'd3, 4'd5);
    repeat (3) step();
    chk("reset_an", {4'h0, bus.an}, 8'h0F);
    chk("reset_seg", bus.seg, 8'hFF);

    // First frame after release.
    rst_n = 1'b1;
    repeat (3) step();
    chk("pre_tick_an", {4'h0, bus.an}, 8'h0F);
    step();
    chk("f1_idx0_an", {4'h0, bus.an}, 8'h07);
    chk("f1_idx0_seg", bus.seg, 8'hF9);
    repeat (CD) step();
    chk("f1_idx1_an", {4'h0, bus.an}, 8'h0B);
    chk("f1_idx1_seg", bus.seg, 8'hA4);
    repeat (CD) step();
    chk("f1_idx2_an", {4'h0, bus.an}, 8'h0D);
    chk("f1_idx2_seg", bus.seg, 8'h30);
    repeat (CD) step();
    chk("f1_idx3_an", {4'h0, bus.an}, 8'h0E);
    chk("f1_idx3_seg", bus.seg, 8'h92);

    // Leading-zero blanking.
    set_in(4'd0, 4'd0, 4'd7, 4'd3);
    wait_slot(0, "sync_blank1");
    chk("blank_idx0", bus.seg, 8'hFF);
    wait_slot(1, "sync_blank1b");
    chk("blank_idx1", bus.seg, 8'hFF);
    wait_slot(2, "sync_blank1c");
    chk("blank_idx2", bus.seg, 8'h78);
    wait_slot(3, "sync_blank1d");
    chk("blank_idx3", bus.seg, 8'hB0);
    set_in(4'd0, 4'd4, 4'd0, 4'd3);
    wait_slot(1, "sync_blank2");
    chk("blank2_idx1", bus.seg, 8'h99);
    wait_slot(2, "sync_blank2b");
    chk("blank2_idx2", bus.seg, 8'h40);

    // Snapshot stability: change units digit mid-slot of idx1.
    set_in(4'd0, 4'd4, 4'd3, 4'd3);
    wait_slot(1, "sync_snap");
    step();
    bus.fenshu0 = 4'd9;
    wait_slot(2, "sync_snap2");
    chk("snap_old", bus.seg, 8'h30);
    wait_slot(2, "sync_snap3");
    chk("snap_new", bus.seg, 8'h10);

    // Invalid BCD dash and hex life.
    set_in(4'd12, 4'd0, 4'd0, 4'd11);
    wait_slot(0, "sync_hex");
    chk("dash_idx0", bus.seg, 8'hBF);
    wait_slot(1, "sync_hex2");
    chk("noblank_idx1", bus.seg, 8'hC0);
    wait_slot(3, "sync_hex3");
    chk("hex_idx3", bus.seg, 8'h83);

    // Game-over blink, then recovery.
    set_in(4'd1, 4'd2, 4'd3, 4'd0);
    repeat (6 * 4 * CD) step();
    bus.shengming = 4'd1;
    repeat (2 * 4 * CD) step();

    // Reset during idx2.
    wait_slot(2, "sync_rst");
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_an", {4'h0, bus.an}, 8'h0F);
    rst_n = 1'b1;
    repeat (CD) step();
    chk("midrst_idx0_an", {4'h0, bus.an}, 8'h07);
    repeat (4 * CD) step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 30; i++) begin
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) bus.fenshu2 = 4'd0;
      if ($urandom_range(0, 3) == 0) bus.shengming = 4'd0;
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(CD, 12 * CD)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
